// File: rtl/anc_filter_v.sv
// NTAPS-tap FIR stage for the ANC path. Coefficients are loaded one per sample strobe
// through a rotating pointer, followed by a two-stage multiply / sum-and-saturate pipeline.
module anc_filter_v #(
  parameter int NTAPS = 8
) (
  input  logic               Clk_100M,
  input  logic               Reset,
  input  logic               FilterEN,
  input  logic signed [10:0] SigIn,
  input  logic signed [10:0] Wz,
  input  logic               Synch,
  output logic signed [10:0] FiltOut
);

  localparam int PW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  logic                 synch_q;
  logic                 evt;
  logic signed [10:0]   x_q [NTAPS];
  logic signed [10:0]   x_d [NTAPS];
  logic signed [10:0]   c_q [NTAPS];
  logic signed [10:0]   c_d [NTAPS];
  logic [PW-1:0]        ptr_q, ptr_d;
  logic signed [21:0]   p_q [NTAPS];
  logic signed [25:0]   sum;
  logic signed [25:0]   shifted;
  logic signed [10:0]   sat;
  logic signed [10:0]   filt_q, filt_d;

  // A strobe edge seen while disabled is consumed by synch_q and never replayed.
  assign evt = Synch & ~synch_q & FilterEN;

  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      x_d[i] = x_q[i];
      c_d[i] = c_q[i];
    end
    if (evt) begin
      x_d[0] = SigIn;
      for (int unsigned i = 1; i < NTAPS; i++) begin
        x_d[i] = x_q[i-1];
      end
      c_d[ptr_q] = Wz;
      ptr_d      = ptr_q + PW'(1);
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      sum = sum + {{4{p_q[i][21]}}, p_q[i]};
    end
    shifted = sum >>> 10;
    if (shifted > 26'sd1023) begin
      sat = 11'sd1023;
    end else if (shifted < -26'sd1024) begin
      sat = -11'sd1024;
    end else begin
      sat = shifted[10:0];
    end
    filt_d = FilterEN ? sat : '0;
  end

  always_ff @(posedge Clk_100M or negedge Reset) begin
    if (!Reset) begin
      synch_q <= 1'b0;
      ptr_q   <= '0;
      filt_q  <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
        p_q[i] <= '0;
      end
    end else begin
      synch_q <= Synch;
      ptr_q   <= ptr_d;
      filt_q  <= filt_d;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        x_q[i] <= x_d[i];
        c_q[i] <= c_d[i];
        p_q[i] <= 22'(x_q[i]) * 22'(c_q[i]);
      end
    end
  end

  assign FiltOut = filt_q;

endmodule

// File: tb/tb_anc_filter_v.sv
// Directed self-checking bench for anc_filter_v with hand-computed expected outputs.
module tb_anc_filter_v;

  logic               Clk_100M = 1'b0;
  logic               Reset    = 1'b0;
  logic               FilterEN = 1'b0;
  logic signed [10:0] SigIn    = '0;
  logic signed [10:0] Wz       = '0;
  logic               Synch    = 1'b0;
  logic signed [10:0] FiltOut;

  int checks = 0;
  int errors = 0;

  anc_filter_v #(.NTAPS(8)) dut (
    .Clk_100M (Clk_100M),
    .Reset    (Reset),
    .FilterEN (FilterEN),
    .SigIn    (SigIn),
    .Wz       (Wz),
    .Synch    (Synch),
    .FiltOut  (FiltOut)
  );

  always #5 Clk_100M = ~Clk_100M;

  task automatic tick();
    @(posedge Clk_100M);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b0;
    Synch    = 1'b0;
    FilterEN = 1'b0;
    SigIn    = '0;
    Wz       = '0;
    repeat (20) tick();
    Reset = 1'b1;
    tick();
  endtask

  // Event at edge k, then edges k+1 and k+2; FiltOut reflects the event afterwards.
  task automatic pulse_and_settle();
    Synch = 1'b1;
    tick();
    Synch = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (20) tick();
    checks++;
    if (FiltOut !== 11'sd0) begin
      errors++;
      $display("FAIL reset_hold: got %0d expected 0", FiltOut);
    end
    Reset    = 1'b1;
    FilterEN = 1'b1;
    SigIn    = 11'sd512;
    Wz       = 11'sd512;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (FiltOut !== 11'sd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %0d expected 0", i, FiltOut);
      end
    end
  endtask

  task automatic test_single_event();
    do_reset();
    FilterEN = 1'b1;
    SigIn    = 11'sd512;
    Wz       = 11'sd512;
    Synch    = 1'b1;
    tick();
    checks++;
    if (FiltOut !== 11'sd0) begin
      errors++;
      $display("FAIL single_edge_k: got %0d expected 0", FiltOut);
    end
    tick();
    checks++;
    if (FiltOut !== 11'sd0) begin
      errors++;
      $display("FAIL single_edge_k1: got %0d expected 0", FiltOut);
    end
    tick();
    checks++;
    if (FiltOut !== 11'sd256) begin
      errors++;
      $display("FAIL single_edge_k2: got %0d expected 256", FiltOut);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (FiltOut !== 11'sd256) begin
        errors++;
        $display("FAIL synch_held cycle %0d: got %0d expected 256", i, FiltOut);
      end
    end
    Synch = 1'b0;
  endtask

  task automatic test_ramp();
    logic signed [10:0] exp_v;
    do_reset();
    FilterEN = 1'b1;
    SigIn    = 11'sd512;
    Wz       = 11'sd512;
    for (int n = 1; n <= 8; n++) begin
      pulse_and_settle();
      exp_v = (256 * n > 1023) ? 11'sd1023 : 11'(256 * n);
      checks++;
      if (FiltOut !== exp_v) begin
        errors++;
        $display("FAIL ramp event %0d: got %0d expected %0d", n, FiltOut, exp_v);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [10:0] exp_v;
    do_reset();
    FilterEN = 1'b1;
    SigIn    = -11'sd1024;
    Wz       = 11'sd1023;
    for (int n = 1; n <= 8; n++) begin
      pulse_and_settle();
      exp_v = (n == 1) ? -11'sd1023 : -11'sd1024;
      checks++;
      if (FiltOut !== exp_v) begin
        errors++;
        $display("FAIL neg_sat event %0d: got %0d expected %0d", n, FiltOut, exp_v);
      end
    end
    do_reset();
    FilterEN = 1'b1;
    SigIn    = 11'sd10;
    Wz       = 11'sd20;
    for (int n = 1; n <= 8; n++) begin
      pulse_and_settle();
      exp_v = (200 * n >= 1024) ? 11'sd1 : 11'sd0;
      checks++;
      if (FiltOut !== exp_v) begin
        errors++;
        $display("FAIL small_sum event %0d: got %0d expected %0d", n, FiltOut, exp_v);
      end
    end
    do_reset();
    FilterEN = 1'b1;
    SigIn    = -11'sd10;
    Wz       = 11'sd20;
    pulse_and_settle();
    checks++;
    if (FiltOut !== -11'sd1) begin
      errors++;
      $display("FAIL floor_negative: got %0d expected -1", FiltOut);
    end
  endtask

  task automatic test_enable();
    do_reset();
    FilterEN = 1'b1;
    SigIn    = 11'sd512;
    Wz       = 11'sd512;
    pulse_and_settle();
    pulse_and_settle();
    checks++;
    if (FiltOut !== 11'sd512) begin
      errors++;
      $display("FAIL enable_pre: got %0d expected 512", FiltOut);
    end
    FilterEN = 1'b0;
    Synch    = 1'b1;
    tick();
    checks++;
    if (FiltOut !== 11'sd0) begin
      errors++;
      $display("FAIL enable_muted: got %0d expected 0", FiltOut);
    end
    FilterEN = 1'b1;
    tick();
    checks++;
    if (FiltOut !== 11'sd512) begin
      errors++;
      $display("FAIL enable_resume: got %0d expected 512", FiltOut);
    end
    Synch = 1'b0;
    tick();
    tick();
    checks++;
    if (FiltOut !== 11'sd512) begin
      errors++;
      $display("FAIL enable_lost_edge: got %0d expected 512", FiltOut);
    end
    Synch = 1'b1;
    tick();
    checks++;
    if (FiltOut !== 11'sd512) begin
      errors++;
      $display("FAIL enable_next_k: got %0d expected 512", FiltOut);
    end
    Synch = 1'b0;
    tick();
    tick();
    checks++;
    if (FiltOut !== 11'sd768) begin
      errors++;
      $display("FAIL enable_next_k2: got %0d expected 768", FiltOut);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [10:0] exp_tab [6];
    exp_tab = '{11'sd0, 11'sd9, 11'sd19, 11'sd29, 11'sd39, 11'sd48};
    do_reset();
    FilterEN = 1'b1;
    SigIn    = 11'sd100;
    Wz       = 11'sd100;
    for (int n = 0; n < 6; n++) begin
      Synch = 1'b1;
      tick();
      checks++;
      if (FiltOut !== exp_tab[n]) begin
        errors++;
        $display("FAIL back_to_back after %0d events: got %0d expected %0d",
                 n, FiltOut, exp_tab[n]);
      end
      Synch = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    FilterEN = 1'b1;
    SigIn    = 11'sd512;
    Wz       = 11'sd512;
    repeat (3) pulse_and_settle();
    checks++;
    if (FiltOut !== 11'sd768) begin
      errors++;
      $display("FAIL midreset_pre: got %0d expected 768", FiltOut);
    end
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (FiltOut !== 11'sd0) begin
      errors++;
      $display("FAIL midreset_async: got %0d expected 0", FiltOut);
    end
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    checks++;
    if (FiltOut !== 11'sd0) begin
      errors++;
      $display("FAIL midreset_release: got %0d expected 0", FiltOut);
    end
    SigIn = 11'sd100;
    Wz    = 11'sd300;
    pulse_and_settle();
    checks++;
    if (FiltOut !== 11'sd29) begin
      errors++;
      $display("FAIL midreset_first: got %0d expected 29", FiltOut);
    end
    SigIn = 11'sd200;
    Wz    = 11'sd1000;
    pulse_and_settle();
    checks++;
    if (FiltOut !== 11'sd156) begin
      errors++;
      $display("FAIL midreset_second: got %0d expected 156", FiltOut);
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_ramp();
    test_saturation();
    test_enable();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
